// File: rtl/bcd_share_arbiter_pkg.sv
// Shared definitions for the BCD converter share arbiter.
//   state_t   : arbiter FSM states
//   DIGIT_W   : width of one BCD digit
//   ERR_DIGIT : digit value reported on a timed-out conversion
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  localparam int             DIGIT_W   = 4;
  localparam logic [DIGIT_W-1:0] ERR_DIGIT = 4'hF;

endpackage

// File: rtl/bcd_share_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i    : request vector
//   ptr_i    : highest-priority index for this pick
//   gnt_id_o : first set request searching ptr_i, ptr_i+1, ... (wrapping)
//   any_o    : 1 when at least one request is set
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   ptr_i,
  output logic [IDW-1:0]   gnt_id_o,
  output logic             any_o
);

  int idx;

  always_comb begin
    gnt_id_o = '0;
    any_o    = 1'b0;
    idx      = int'(ptr_i);
    for (int k = 0; k < N_REQ; k++) begin
      if (!any_o && req_i[idx]) begin
        any_o    = 1'b1;
        gnt_id_o = IDW'(idx);
      end
      // Explicit wrap so non-power-of-two N_REQ rotates correctly.
      idx = (idx == N_REQ - 1) ? 0 : idx + 1;
    end
  end

endmodule

// File: rtl/bcd_share_arbiter.sv
// Shares one BCD converter among N_REQ clients with round-robin grant.
//   clk, rst            : clock, asynchronous active-low reset
//   req / bin           : per-client request level and operand
//   ack                 : one-cycle pulse to the served client, res_* valid then
//   res_und/dec/cen/err : result digits and timeout flag (held until next delivery)
//   busy                : FSM not in IDLE
//   bcd_init / bcd_bin  : converter start pulse and registered operand
//   bcd_und/dec/cen     : converter digits
//   bcd_done            : converter done level
//   dbg_state, dbg_ptr  : FSM state and round-robin pointer for observation
//
// Handshake: a client raises req[i] with bin[i] stable and keeps it high
// until ack[i]; the operand is latched at grant, so later changes to bin[i]
// or dropping req[i] do not affect the service in flight, and ack[i] is
// always pulsed for it (unless reset intervenes).
module bcd_share_arbiter
  import bcd_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int BIN_W   = 9,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*BIN_W-1:0]   bin,
  output logic [N_REQ-1:0]         ack,
  output logic [DIGIT_W-1:0]       res_und,
  output logic [DIGIT_W-1:0]       res_dec,
  output logic [DIGIT_W-1:0]       res_cen,
  output logic                     res_err,
  output logic                     busy,
  output logic                     bcd_init,
  output logic [BIN_W-1:0]         bcd_bin,
  input  logic [DIGIT_W-1:0]       bcd_und,
  input  logic [DIGIT_W-1:0]       bcd_dec,
  input  logic [DIGIT_W-1:0]       bcd_cen,
  input  logic                     bcd_done,
  output state_t                   dbg_state,
  output logic [$clog2(N_REQ)-1:0] dbg_ptr
);

  localparam int IDW = $clog2(N_REQ);
  localparam int TW  = $clog2(TIMEOUT);

  state_t               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       gnt_q, gnt_d;
  logic [BIN_W-1:0]     bin_q, bin_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 done_q;
  logic [DIGIT_W-1:0]   und_q, und_d, dec_q, dec_d, cen_q, cen_d;
  logic                 err_q, err_d;

  logic [IDW-1:0]       pick_id;
  logic                 pick_any;
  logic                 done_edge;

  rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .gnt_id_o (pick_id),
    .any_o    (pick_any)
  );

  // Only a fresh rise counts: a done level left over from the previous
  // conversion must not complete the current one.
  assign done_edge = bcd_done & ~done_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    bin_d   = bin_q;
    timer_d = timer_q;
    und_d   = und_q;
    dec_d   = dec_q;
    cen_d   = cen_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_id;
          bin_d   = bin[int'(pick_id)*BIN_W +: BIN_W];
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (timer_q != {TW{1'b1}}) timer_d = timer_q + TW'(1);
        // Edge is tested first so it wins over a coincident timeout.
        if (done_edge) begin
          und_d   = bcd_und;
          dec_d   = bcd_dec;
          cen_d   = bcd_cen;
          err_d   = 1'b0;
          state_d = DELIVER;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          und_d   = ERR_DIGIT;
          dec_d   = ERR_DIGIT;
          cen_d   = ERR_DIGIT;
          err_d   = 1'b1;
          state_d = DELIVER;
        end
      end
      DELIVER: begin
        ptr_d   = (gnt_q == IDW'(N_REQ - 1)) ? '0 : gnt_q + IDW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      bin_q   <= '0;
      timer_q <= '0;
      done_q  <= 1'b0;
      und_q   <= '0;
      dec_q   <= '0;
      cen_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      bin_q   <= bin_d;
      timer_q <= timer_d;
      done_q  <= bcd_done;
      und_q   <= und_d;
      dec_q   <= dec_d;
      cen_q   <= cen_d;
      err_q   <= err_d;
    end
  end

  assign ack       = (state_q == DELIVER) ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_q) : '0;
  assign bcd_init  = (state_q == LAUNCH);
  assign busy      = (state_q != IDLE);
  assign bcd_bin   = bin_q;
  assign res_und   = und_q;
  assign res_dec   = dec_q;
  assign res_cen   = cen_q;
  assign res_err   = err_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_bcd_share_arbiter.sv
module tb_bcd_share_arbiter;
  import bcd_pkg::*;

  localparam int N = 4;
  localparam int W = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req;
  logic [N*W-1:0] bin;
  logic [N-1:0]   ack;
  logic [3:0]     res_und, res_dec, res_cen;
  logic           res_err, busy, bcd_init;
  logic [W-1:0]   bcd_bin;
  logic [3:0]     bcd_und, bcd_dec, bcd_cen;
  logic           bcd_done;
  state_t         dbg_state;
  logic [1:0]     dbg_ptr;

  bcd_share_arbiter #(.N_REQ(N), .BIN_W(W), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req), .bin(bin), .ack(ack),
    .res_und(res_und), .res_dec(res_dec), .res_cen(res_cen), .res_err(res_err),
    .busy(busy), .bcd_init(bcd_init), .bcd_bin(bcd_bin),
    .bcd_und(bcd_und), .bcd_dec(bcd_dec), .bcd_cen(bcd_cen), .bcd_done(bcd_done),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  // ---------------- converter model ----------------
  // mode 0: normal, 1: never done, 2: done stuck high at init, falls later
  int           cv_mode  = 0;
  int           cv_delay = 10;
  int           cv_cnt;
  bit           cv_active;
  logic [W-1:0] cv_lat;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      bcd_done  = 1'b0;
      cv_active = 1'b0;
      cv_cnt    = 0;
      bcd_und   = 4'd0;
      bcd_dec   = 4'd0;
      bcd_cen   = 4'd0;
    end else if (bcd_init) begin
      cv_active = 1'b1;
      cv_cnt    = 0;
      cv_lat    = bcd_bin;
      if (cv_mode != 2) bcd_done = 1'b0;
    end else if (cv_active) begin
      cv_cnt++;
      if (cv_mode == 2 && cv_cnt == 3) bcd_done = 1'b0;
      if (cv_cnt == cv_delay && cv_mode != 1) begin
        bcd_und   = 4'(cv_lat % 10);
        bcd_dec   = 4'((cv_lat / 10) % 10);
        bcd_cen   = 4'(cv_lat / 100);
        bcd_done  = 1'b1;
        cv_active = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic reset_checks(input string tag);
    check_val({tag, "_ack"},   32'(ack), 32'd0);
    check_val({tag, "_busy"},  32'(busy), 32'd0);
    check_val({tag, "_init"},  32'(bcd_init), 32'd0);
    check_val({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    check_val({tag, "_ptr"},   32'(dbg_ptr), 32'd0);
    check_val({tag, "_res"},   {19'd0, res_err, res_cen, res_dec, res_und}, 32'd0);
    check_val({tag, "_bin"},   32'(bcd_bin), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks(tag);
    rst = 1'b1;
  endtask

  // Waits for the launch, then counts cycles until ack; drop_at>0 removes
  // the request and scrambles the operand that many cycles after launch.
  task automatic serve(input string tag, input int idx, input logic [3:0] e_cen,
                       input logic [3:0] e_dec, input logic [3:0] e_und,
                       input logic e_err, input int e_lat, input int drop_at);
    int n;
    int inits;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bcd_init) seen = 1'b1;
    end
    check_val({tag, "_init_seen"}, 32'(seen), 32'd1);
    n = 0; inits = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (bcd_init) inits++;
      if (n == drop_at) begin
        req[idx]       = 1'b0;
        bin[idx*W +: W] = '0;
      end
      if (ack != '0) seen = 1'b1;
    end
    check_val({tag, "_ack_seen"},  32'(seen), 32'd1);
    check_val({tag, "_latency"},   32'(n), 32'(e_lat));
    check_val({tag, "_ack"},       32'(ack), 32'(1 << idx));
    check_val({tag, "_digits"},    {20'd0, res_cen, res_dec, res_und}, {20'd0, e_cen, e_dec, e_und});
    check_val({tag, "_err"},       32'(res_err), 32'(e_err));
    check_val({tag, "_one_init"},  32'(inits), 32'd0);
    check_val({tag, "_busy"},      32'(busy), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    req = '0;
    bin = '0;
    #12;
    reset_checks("por");
    rst = 1'b1;

    // 1: single client, 255 -> 2,5,5
    bin[0*W +: W] = 9'd255;
    req[0] = 1'b1;
    serve("t1", 0, 4'd2, 4'd5, 4'd5, 1'b0, 11, 0);
    req[0] = 1'b0;
    @(negedge clk);
    check_val("t1_ack_one_cycle", 32'(ack), 32'd0);

    // 2: all four held from ptr=0 -> 0,1,2,3,0
    do_reset("rst2");
    bin = {9'd309, 9'd78, 9'd456, 9'd123};
    req = 4'b1111;
    serve("t2_a0", 0, 4'd1, 4'd2, 4'd3, 1'b0, 11, 0);
    serve("t2_a1", 1, 4'd4, 4'd5, 4'd6, 1'b0, 11, 0);
    serve("t2_a2", 2, 4'd0, 4'd7, 4'd8, 1'b0, 11, 0);
    serve("t2_a3", 3, 4'd3, 4'd0, 4'd9, 1'b0, 11, 0);
    serve("t2_a4", 0, 4'd1, 4'd2, 4'd3, 1'b0, 11, 0);
    req = '0;

    // 3: converter never completes -> timeout after 64 WAIT cycles
    cv_mode = 1;
    bin[3*W +: W] = 9'd100;
    req[3] = 1'b1;
    serve("t3_to", 3, 4'hF, 4'hF, 4'hF, 1'b1, 65, 0);
    cv_mode = 0;
    bin[3*W +: W] = 9'd42;
    serve("t3_next", 3, 4'd0, 4'd4, 4'd2, 1'b0, 11, 0);
    req[3] = 1'b0;

    // 4: done still high from previous run at launch
    cv_mode = 2;
    bin[0*W +: W] = 9'd7;
    req[0] = 1'b1;
    serve("t4", 0, 4'd0, 4'd0, 4'd7, 1'b0, 11, 0);
    req[0] = 1'b0;
    cv_mode = 0;

    // 5: reset during WAIT with client 2 requesting
    bin[2*W +: W] = 9'd300;
    req = 4'b0100;
    begin
      bit seen_i;
      seen_i = 1'b0;
      for (int i = 0; i < 20 && !seen_i; i++) begin
        @(negedge clk);
        if (bcd_init) seen_i = 1'b1;
      end
      check_val("t5_init_seen", 32'(seen_i), 32'd1);
    end
    repeat (4) @(negedge clk);
    check_val("t5_in_wait", 32'(dbg_state), 32'(WAIT));
    rst = 1'b0;
    #1;
    reset_checks("t5_rst");
    begin
      int acks;
      acks = 0;
      repeat (2) begin
        @(negedge clk);
        if (ack != '0) acks++;
        if (bcd_init) acks++;
      end
      check_val("t5_quiet_in_rst", 32'(acks), 32'd0);
    end
    rst = 1'b1;
    serve("t5_reserve", 2, 4'd3, 4'd0, 4'd0, 1'b0, 11, 0);
    req = '0;

    // 6: client 1 drops req and changes bin during WAIT
    bin[1*W +: W] = 9'd511;
    req[1] = 1'b1;
    serve("t6", 1, 4'd5, 4'd1, 4'd1, 1'b0, 11, 3);
    req = '0;
    @(negedge clk);
    check_val("t6_idle_after", 32'(busy), 32'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
